delay_sched: RTL and testbench
==============================

Name: delay_sched

Overview:
- Shared-timer scheduler: one CBITS-wide delay counter is time-shared among NREQ requesters.
- Each requester asks for a delay of its own length. A round-robin arbiter grants the counter to one requester at a time.
- When the granted delay expires, the block returns a one-cycle done pulse to that requester.
- Sits between the block's periodic/timeout consumers and a single counter resource, so each consumer does not need its own delay counter.

Parameters:
- NREQ, 4, number of requesters (2..8).
- CBITS, 10, counter and delay-length width.
- IDW, 2, width of grant index; must equal ceil(log2(NREQ)).

Ports:
- clk  input  1  clock, all state updates on posedge.
- rst  input  1  synchronous active-high reset.
- req  input  NREQ  per-requester level request; held high until done or withdrawn.
- len  input  NREQ*CBITS  per-requester delay length, slice i = len[i*CBITS +: CBITS].
- busy  output  1  high while the counter is owned (RUN or DONE state).
- gnt_id  output  IDW  index of current/last owner.
- cnt  output  CBITS  current counter value (observability).
- done  output  NREQ  one-hot, one-cycle expiry pulse to the owner.
- abort  output  1  one-cycle pulse when the owner withdraws req during RUN.

Behaviour:
- Reset: on the rising edge with rst=1, the block goes to IDLE and busy=0, gnt_id=0, cnt=0, done=0, abort=0, rr pointer ptr=0. rst has priority over every other event, including mid-RUN and the DONE cycle. No done is issued for an in-flight delay.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - If req != 0, grant the first asserted req at or after ptr, searching ptr, ptr+1, ..., wrapping mod NREQ.
  - Next state is RUN. Set gnt_id to the winner, cnt=0, busy=1.
  - Latch len slice of the winner into len_q. Later changes to len are ignored until the next grant.
  - If req == 0, stay in IDLE with cnt=0.
- RUN:
  - If req[gnt_id]=0: next state IDLE, abort=1 for one cycle, busy=0, ptr=gnt_id+1 mod NREQ, cnt=0.
  - Else if cnt == len_q: next state DONE, done[gnt_id]=1.
  - Else cnt = cnt+1.
  - Abort takes priority over expiry in the same cycle.
- DONE:
  - done is high for exactly this one cycle, and busy is still 1.
  - Next state is IDLE. done=0, busy=0, cnt=0, ptr=gnt_id+1 mod NREQ.
- Latency:
  - Grant at edge E0 → done=1 after edge E0+len_q+1.
  - len_q=0 → done after E0+1.
  - RUN therefore lasts len_q+1 cycles.
- Back-to-back: the next grant is made at edge E0+len_q+3 (one IDLE cycle after DONE). A requester still holding req after its done is treated as a new request and competes normally.
- Fairness: ptr advances past the served or aborted requester. With all req high, the grant order is 0,1,2,3,0,...
- Width: cnt is CBITS bits and never wraps, since it stops at len_q ≤ 2^CBITS-1. len_q = all-ones is legal and gives 2^CBITS cycles in RUN.
- Changes to req of non-owners during RUN/DONE have no effect until IDLE.
- done and abort are never high in the same cycle. At most one done bit is set.

Test Plan:
- Reset/idle: rst=1 for 2 cycles with req=4'b1111 → busy=0, done=0, cnt=0, gnt_id=0. Release rst with req=0 → stays IDLE.
- Single delay: req[2]=1, len[2]=5, granted at E0 → gnt_id=2, cnt counts 0..5, done=4'b0100 one cycle after E0+6, busy falls the next cycle. Boundary: len[0]=0 → done after E0+1.
- Round-robin: req=4'b1111 held, all len=3 → grants in order 0,1,2,3,0, each done spaced 6 cycles apart. Then req=4'b1010 held with ptr=1 → 1,3,1.
- Abort: req[1]=1, len[1]=10; drop req[1] when cnt=4 → abort pulse, no done, next grant to requester 2 if pending. Abort and expiry coincident (drop req when cnt==len_q) → abort only.
- Len latch and max: grant req[3] with len[3]=2, then change len[3]=9 during RUN → done after 2. Set CBITS=4, len=15 → RUN lasts 16 cycles with no cnt wrap.
- Reset mid-op: rst=1 while cnt=7 in RUN → next cycle busy=0, cnt=0, no done or abort. rst during DONE → done deasserted next cycle, ptr=0.

Source files
------------

// File: rtl/delay_sched_if.sv
// delay_sched_if: request/response bundle between requesters and the shared delay timer.
// Signals:
//   req    requester -> timer, per-requester level request
//   len    requester -> timer, per-requester delay length (slice i = len[i*CBITS +: CBITS])
//   busy   timer -> requester, counter owned (RUN or DONE)
//   gnt_id timer -> requester, index of current/last owner
//   cnt    timer -> requester, current counter value
//   done   timer -> requester, one-hot one-cycle expiry pulse
//   abort  timer -> requester, one-cycle pulse when the owner withdraws during RUN
interface delay_sched_if #(
    parameter int NREQ  = 4,
    parameter int CBITS = 10,
    parameter int IDW   = 2
);
    logic [NREQ-1:0]       req;
    logic [NREQ*CBITS-1:0] len;
    logic                  busy;
    logic [IDW-1:0]        gnt_id;
    logic [CBITS-1:0]      cnt;
    logic [NREQ-1:0]       done;
    logic                  abort;
    modport master (output req, len, input busy, gnt_id, cnt, done, abort);
    modport slave  (input req, len, output busy, gnt_id, cnt, done, abort);
endinterface

// File: rtl/delay_sched.sv
// delay_sched: one delay counter time-shared among NREQ requesters with round-robin grant.
// Ports:
//   clk  clock, all state updates on posedge
//   rst  synchronous active-high reset
//   bus  delay_sched_if slave side (req/len in; busy/gnt_id/cnt/done/abort out, all registered)
module delay_sched #(
    parameter int NREQ  = 4,
    parameter int CBITS = 10,
    parameter int IDW   = 2
) (
    input  logic          clk,
    input  logic          rst,
    delay_sched_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    logic [1:0]       state_q, state_d;
    logic [IDW-1:0]   gnt_q, gnt_d, ptr_q, ptr_d, win, nxt;
    logic [CBITS-1:0] cnt_q, cnt_d, len_q, len_d;
    logic [NREQ-1:0]  done_q, done_d;
    logic             abort_q, abort_d, found;
    // Scan offsets from the far end down so the nearest asserted request at/after ptr wins.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.req[(int'(ptr_q) + k) % NREQ]) begin
                win   = IDW'((int'(ptr_q) + k) % NREQ);
                found = 1'b1;
            end
        end
    end
    assign nxt = (gnt_q == IDW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        done_d  = '0;
        abort_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (found) begin
                    state_d = RUN;
                    gnt_d   = win;
                    len_d   = bus.len[int'(win)*CBITS +: CBITS];
                end
            end
            RUN: begin
                // Withdrawal outranks expiry so done and abort never coincide.
                if (!bus.req[gnt_q]) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                    ptr_d   = nxt;
                    cnt_d   = '0;
                end else if (cnt_q == len_q) begin
                    state_d = DONE;
                    done_d  = NREQ'(1) << gnt_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
                ptr_d   = nxt;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            done_q  <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end
    assign bus.busy   = state_q != IDLE;
    assign bus.gnt_id = gnt_q;
    assign bus.cnt    = cnt_q;
    assign bus.done   = done_q;
    assign bus.abort  = abort_q;
endmodule

// File: tb/tb_delay_sched.sv
// tb_delay_sched: directed stimulus with a scoreboard of expected done/abort pulses.
module tb_delay_sched;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    delay_sched_if #(.NREQ(4), .CBITS(10), .IDW(2)) bus ();
    delay_sched_if #(.NREQ(2), .CBITS(4), .IDW(1)) sbus ();
    delay_sched #(.NREQ(4), .CBITS(10), .IDW(2)) dut (.clk(clk), .rst(rst), .bus(bus));
    delay_sched #(.NREQ(2), .CBITS(4), .IDW(1)) u_small (.clk(clk), .rst(rst), .bus(sbus));
    typedef struct {
        logic       ab;
        logic [3:0] dn;
        logic [1:0] id;
        int         at;
    } exp_t;
    exp_t q[$];
    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic push(input logic ab, input logic [3:0] dn, input logic [1:0] id, input int at);
        exp_t e;
        e.ab = ab; e.dn = dn; e.id = id; e.at = at;
        q.push_back(e);
    endtask
    task automatic set_len(input int id, input int v);
        bus.len[id*10 +: 10] = 10'(v);
    endtask
    task automatic do_reset();
        rst = 1'b1;
        bus.req = '0;
        tick(2);
        rst = 1'b0;
    endtask
    task automatic run_one(input int id, input int l);
        int c;
        c = cyc;
        set_len(id, l);
        bus.req = 4'(1) << id;
        push(1'b0, 4'(1) << id, 2'(id), c + l + 2);
        tick(1);
        chk("grant_id", bus.gnt_id, id);
        chk("grant_busy", bus.busy, 1);
        chk("grant_cnt", bus.cnt, 0);
        tick(l);
        chk("cnt_at_len", bus.cnt, l);
        chk("no_early_done", bus.done, 0);
        tick(1);
        chk("busy_in_done", bus.busy, 1);
        bus.req = '0;
        tick(1);
        chk("busy_after_done", bus.busy, 0);
        tick(1);
    endtask
    // Monitor: every done/abort pulse must match the oldest scoreboard entry.
    always @(negedge clk) begin
        if (bus.done !== 4'b0 || bus.abort !== 1'b0) begin
            if (q.size() == 0) begin
                chk("unexpected_pulse", {bus.abort, bus.done}, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("pulse_abort", bus.abort, e.ab);
                chk("pulse_done", bus.done, e.dn);
                chk("pulse_id", bus.gnt_id, e.id);
                chk("pulse_cycle", cyc, e.at);
            end
        end
    end
    initial begin
        #200000;
        $display("FAIL timeout: run did not finish");
        $fatal(1);
    end
    initial begin
        int c;
        rst = 1'b1;
        bus.req = 4'b1111;
        bus.len = '0;
        sbus.req = '0;
        sbus.len = '0;
        tick(2);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_cnt", bus.cnt, 0);
        chk("rst_gnt", bus.gnt_id, 0);
        chk("rst_abort", bus.abort, 0);
        rst = 1'b0;
        bus.req = '0;
        tick(3);
        chk("idle_busy", bus.busy, 0);
        chk("idle_cnt", bus.cnt, 0);
        run_one(2, 5);
        run_one(0, 0);
        do_reset();
        c = cyc;
        for (int i = 0; i < 4; i++) set_len(i, 3);
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) push(1'b0, 4'(1) << (k % 4), 2'(k % 4), c + 5 + 6*k);
        tick(29);
        bus.req = '0;
        tick(2);
        c = cyc;
        bus.req = 4'b1010;
        push(1'b0, 4'b0010, 2'd1, c + 5);
        push(1'b0, 4'b1000, 2'd3, c + 11);
        push(1'b0, 4'b0010, 2'd1, c + 17);
        tick(17);
        bus.req = '0;
        tick(2);
        do_reset();
        c = cyc;
        set_len(1, 10);
        set_len(2, 2);
        bus.req = 4'b0110;
        tick(5);
        chk("abort_pre_cnt", bus.cnt, 4);
        chk("abort_pre_gnt", bus.gnt_id, 1);
        bus.req = 4'b0100;
        push(1'b1, 4'b0000, 2'd1, c + 6);
        tick(2);
        chk("post_abort_gnt", bus.gnt_id, 2);
        chk("post_abort_busy", bus.busy, 1);
        push(1'b0, 4'b0100, 2'd2, c + 10);
        tick(3);
        bus.req = '0;
        tick(2);
        c = cyc;
        set_len(3, 3);
        bus.req = 4'b1000;
        tick(4);
        chk("coinc_cnt", bus.cnt, 3);
        bus.req = '0;
        push(1'b1, 4'b0000, 2'd3, c + 5);
        tick(3);
        c = cyc;
        set_len(3, 2);
        bus.req = 4'b1000;
        push(1'b0, 4'b1000, 2'd3, c + 4);
        tick(1);
        set_len(3, 9);
        tick(3);
        bus.req = '0;
        tick(2);
        set_len(0, 20);
        bus.req = 4'b0001;
        tick(8);
        chk("mid_cnt", bus.cnt, 7);
        chk("mid_busy", bus.busy, 1);
        rst = 1'b1;
        tick(1);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_cnt", bus.cnt, 0);
        chk("mid_rst_done", bus.done, 0);
        chk("mid_rst_abort", bus.abort, 0);
        rst = 1'b0;
        bus.req = '0;
        tick(2);
        c = cyc;
        set_len(0, 1);
        bus.req = 4'b0001;
        push(1'b0, 4'b0001, 2'd0, c + 3);
        tick(3);
        rst = 1'b1;
        tick(1);
        chk("done_rst_done", bus.done, 0);
        chk("done_rst_busy", bus.busy, 0);
        set_len(0, 50);
        set_len(1, 50);
        rst = 1'b0;
        bus.req = 4'b0011;
        c = cyc;
        tick(1);
        chk("ptr_after_rst", bus.gnt_id, 0);
        bus.req = '0;
        push(1'b1, 4'b0000, 2'd0, c + 2);
        tick(3);
        sbus.len = 8'h0F;
        sbus.req = 2'b01;
        tick(1);
        chk("small_busy", sbus.busy, 1);
        chk("small_cnt0", sbus.cnt, 0);
        tick(15);
        chk("small_cnt_max", sbus.cnt, 15);
        chk("small_no_done", sbus.done, 0);
        chk("small_busy_run", sbus.busy, 1);
        tick(1);
        chk("small_done", sbus.done, 1);
        sbus.req = '0;
        tick(2);
        chk("small_idle", sbus.busy, 0);
        chk("queue_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
